// File: rtl/noc_vc_switch_alloc_pkg.sv
// Shared definitions for the 5-port mesh switch allocator: port indices, one-hot
// route targets, default flit/hop geometry and the dimension-order routing mode.
package noc_vc_switch_alloc_pkg;

   localparam int NUM_PORTS  = 5;
   localparam int PORT_UP    = 0;
   localparam int PORT_DOWN  = 1;
   localparam int PORT_LEFT  = 2;
   localparam int PORT_RIGHT = 3;
   localparam int PORT_PE    = 4;

   localparam logic [NUM_PORTS-1:0] GOING_UP    = 5'b00001;
   localparam logic [NUM_PORTS-1:0] GOING_DOWN  = 5'b00010;
   localparam logic [NUM_PORTS-1:0] GOING_LEFT  = 5'b00100;
   localparam logic [NUM_PORTS-1:0] GOING_RIGHT = 5'b01000;
   localparam logic [NUM_PORTS-1:0] GOING_PE    = 5'b10000;

   localparam int DATA_W_DEF   = 64;
   localparam int HOP_X_LO_DEF = 52;
   localparam int HOP_Y_LO_DEF = 48;
   localparam int HOP_W_DEF    = 4;

   typedef enum logic {
      ROUTE_MODE_XY = 1'b0,
      ROUTE_MODE_YX = 1'b1
   } route_e;

endpackage

// File: rtl/noc_vc_switch_alloc_if.sv
// Allocator-side bundle: flat per-VC input/output buffer status, run/phase control and
// the sticky U-turn error. Flat index f = port*NUM_VC + vc.
interface noc_vc_switch_alloc_if #(
   parameter int NUM_VC = 2,
   parameter int DATA_W = 64
);
   localparam int PH_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic                       run;
   logic                       err_clear;
   logic [5*NUM_VC-1:0]        in_valid;
   logic [5*NUM_VC*DATA_W-1:0] in_data;
   logic [5*NUM_VC-1:0]        out_empty;
   logic [5*NUM_VC-1:0]        in_clear;
   logic [5*NUM_VC-1:0]        out_enable;
   logic [5*DATA_W-1:0]        out_data;
   logic [PH_W-1:0]            vc_phase;
   logic                       uturn_err;

   modport master (
      output run, err_clear, in_valid, in_data, out_empty,
      input  in_clear, out_enable, out_data, vc_phase, uturn_err
   );

   modport slave (
      input  run, err_clear, in_valid, in_data, out_empty,
      output in_clear, out_enable, out_data, vc_phase, uturn_err
   );

endinterface

// File: rtl/noc_vc_switch_alloc_rr_arbiter_bank.sv
// 5-way round-robin arbiter with one pointer per VC bank; combinational grant,
// pointer moves to the winner only when a grant issues (ineligible output -> no grant).
module noc_vc_switch_alloc_rr_arbiter_bank
   import noc_vc_switch_alloc_pkg::*;
#(
   parameter int PH_W = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic                 i_eligible,
   input  logic [PH_W-1:0]      i_bank,
   output logic [NUM_PORTS-1:0] o_gnt
);
   localparam int NB = 1 << PH_W;

   logic [2:0] r_ptr [NB];
   logic [2:0] w_gnt_idx;

   // Scan from lowest to highest priority so the closest requester after ptr wins last.
   always_comb begin
      int idx;
      idx       = 0;
      o_gnt     = '0;
      w_gnt_idx = r_ptr[i_bank];
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = (int'(r_ptr[i_bank]) + k) % NUM_PORTS;
         if (i_eligible && i_req[idx]) begin
            o_gnt     = 5'b00001 << idx;
            w_gnt_idx = 3'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < NB; b++) r_ptr[b] <= 3'(PORT_PE);
      end else if (|o_gnt) begin
         r_ptr[i_bank] <= w_gnt_idx;
      end
   end

endmodule

// File: rtl/noc_vc_switch_alloc.sv
// Switch allocator for a 5-port mesh router, one VC per cycle: in_clear in the grant cycle,
// out_enable/out_data one cycle later; full or in-flight output VCs simply withhold grants.
module noc_vc_switch_alloc
   import noc_vc_switch_alloc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_VC   = 2,
   parameter int HOP_X_LO = HOP_X_LO_DEF,
   parameter int HOP_Y_LO = HOP_Y_LO_DEF,
   parameter int HOP_W    = HOP_W_DEF,
   parameter bit ROUTE_YX = 1'b0
) (
   input logic                 clk,
   input logic                 reset_n,
   noc_vc_switch_alloc_if.slave bus
);
   localparam int     PH_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int     NF   = NUM_PORTS * NUM_VC;
   localparam route_e MODE = ROUTE_YX ? ROUTE_MODE_YX : ROUTE_MODE_XY;

   logic [PH_W-1:0]             r_phase;
   logic [NF-1:0]               r_out_enable;
   logic [NUM_PORTS*DATA_W-1:0] r_out_data;
   logic                        r_uturn_err;

   int                          w_vc;
   logic [NUM_PORTS-1:0]        w_vld;
   logic [NUM_PORTS-1:0]        w_uturn;
   logic [NUM_PORTS-1:0]        w_elig;
   logic [NUM_PORTS-1:0]        w_tgt  [NUM_PORTS];
   logic [DATA_W-1:0]           w_flit [NUM_PORTS];
   logic [NUM_PORTS-1:0]        w_req  [NUM_PORTS];
   logic [NUM_PORTS-1:0]        w_gnt  [NUM_PORTS];
   logic [NF-1:0]               w_clear;
   logic [NF-1:0]               w_en_nxt;
   logic [NUM_PORTS*DATA_W-1:0] w_dat_nxt;

   assign w_vc = int'(r_phase);

   // Route decode of the active VC; w_flit carries the flit with its resolved hop stepped.
   always_comb begin
      logic signed [HOP_W-1:0] x;
      logic signed [HOP_W-1:0] y;
      logic                    use_x;
      logic                    use_y;
      x = '0;
      y = '0;
      use_x = 1'b0;
      use_y = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_flit[i] = bus.in_data[(i*NUM_VC + w_vc)*DATA_W +: DATA_W];
         w_vld[i]  = bus.run & bus.in_valid[i*NUM_VC + w_vc];
         x = signed'(w_flit[i][HOP_X_LO +: HOP_W]);
         y = signed'(w_flit[i][HOP_Y_LO +: HOP_W]);
         use_x = (x != 0) && ((MODE == ROUTE_MODE_XY) || (y == 0));
         use_y = !use_x && (y != 0);
         w_tgt[i] = GOING_PE;
         if (use_x) begin
            w_tgt[i] = (x < 0) ? GOING_LEFT : GOING_RIGHT;
            w_flit[i][HOP_X_LO +: HOP_W] = (x < 0) ? x + HOP_W'(1) : x - HOP_W'(1);
         end else if (use_y) begin
            w_tgt[i] = (y < 0) ? GOING_UP : GOING_DOWN;
            w_flit[i][HOP_Y_LO +: HOP_W] = (y < 0) ? y + HOP_W'(1) : y - HOP_W'(1);
         end
         w_uturn[i] = w_vld[i] && (i != PORT_PE) && w_tgt[i][i];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_elig[p] = bus.out_empty[p*NUM_VC + w_vc] & ~r_out_enable[p*NUM_VC + w_vc];
         w_req[p]  = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_req[p][i] = w_vld[i] & w_tgt[i][p] & ~w_uturn[i];
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
      noc_vc_switch_alloc_rr_arbiter_bank #(
         .PH_W (PH_W)
      ) u_arb (
         .clk        (clk),
         .reset_n    (reset_n),
         .i_req      (w_req[p]),
         .i_eligible (w_elig[p]),
         .i_bank     (r_phase),
         .o_gnt      (w_gnt[p])
      );
   end

   always_comb begin
      w_clear   = '0;
      w_en_nxt  = '0;
      w_dat_nxt = r_out_data;
      for (int i = 0; i < NUM_PORTS; i++) w_clear[i*NUM_VC + w_vc] = w_uturn[i];
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt[p][i]) begin
               w_clear[i*NUM_VC + w_vc]      = 1'b1;
               w_dat_nxt[p*DATA_W +: DATA_W] = w_flit[i];
            end
         end
         w_en_nxt[p*NUM_VC + w_vc] = |w_gnt[p];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase      <= '0;
         r_out_enable <= '0;
         r_out_data   <= '0;
         r_uturn_err  <= 1'b0;
      end else begin
         if (bus.run) r_phase <= (int'(r_phase) == NUM_VC-1) ? '0 : r_phase + 1'b1;
         r_out_enable <= w_en_nxt;
         r_out_data   <= w_dat_nxt;
         if (|w_uturn)          r_uturn_err <= 1'b1;
         else if (bus.err_clear) r_uturn_err <= 1'b0;
      end
   end

   assign bus.in_clear   = w_clear;
   assign bus.out_enable = r_out_enable;
   assign bus.out_data   = r_out_data;
   assign bus.vc_phase   = r_phase;
   assign bus.uturn_err  = r_uturn_err;

endmodule

// File: tb/tb_noc_vc_switch_alloc.sv
// Scoreboard bench: three allocator instances (XY NUM_VC=2, YX NUM_VC=2, XY NUM_VC=1).
module tb_noc_vc_switch_alloc;

   typedef struct {
      int          idx;
      logic [63:0] dat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   noc_vc_switch_alloc_if #(.NUM_VC(2), .DATA_W(64)) ifc_a ();
   noc_vc_switch_alloc_if #(.NUM_VC(2), .DATA_W(64)) ifc_b ();
   noc_vc_switch_alloc_if #(.NUM_VC(1), .DATA_W(64)) ifc_c ();

   noc_vc_switch_alloc #(.DATA_W(64), .NUM_VC(2), .HOP_X_LO(52), .HOP_Y_LO(48), .HOP_W(4), .ROUTE_YX(1'b0))
      u_xy (.clk(clk), .reset_n(reset_n), .bus(ifc_a));
   noc_vc_switch_alloc #(.DATA_W(64), .NUM_VC(2), .HOP_X_LO(52), .HOP_Y_LO(48), .HOP_W(4), .ROUTE_YX(1'b1))
      u_yx (.clk(clk), .reset_n(reset_n), .bus(ifc_b));
   noc_vc_switch_alloc #(.DATA_W(64), .NUM_VC(1), .HOP_X_LO(52), .HOP_Y_LO(48), .HOP_W(4), .ROUTE_YX(1'b0))
      u_v1 (.clk(clk), .reset_n(reset_n), .bus(ifc_c));

   function automatic logic [63:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [47:0] pl);
      return {8'hA5, x, y, pl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase_a(input int ph);
      for (int k = 0; k < 4 && int'(ifc_a.vc_phase) != ph; k++) step();
      if (int'(ifc_a.vc_phase) != ph) begin
         n_total++;
         $display("FAIL phase_wait_a: got %0d want %0d", ifc_a.vc_phase, ph);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ifc_a.run = 0; ifc_a.err_clear = 0; ifc_a.in_valid = '0; ifc_a.in_data = '0; ifc_a.out_empty = '1;
      ifc_b.run = 0; ifc_b.err_clear = 0; ifc_b.in_valid = '0; ifc_b.in_data = '0; ifc_b.out_empty = '1;
      ifc_c.run = 0; ifc_c.err_clear = 0; ifc_c.in_valid = '0; ifc_c.in_data = '0; ifc_c.out_empty = '1;
      step(); step();
      n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL rst_out_enable: got %0h want 0", ifc_a.out_enable); else n_pass++;
      n_total++; if (ifc_a.out_data !== 320'h0) $display("FAIL rst_out_data: got %0h want 0", ifc_a.out_data); else n_pass++;
      n_total++; if (ifc_a.vc_phase !== 1'b0) $display("FAIL rst_vc_phase: got %0h want 0", ifc_a.vc_phase); else n_pass++;
      n_total++; if (ifc_a.uturn_err !== 1'b0) $display("FAIL rst_uturn_err: got %0h want 0", ifc_a.uturn_err); else n_pass++;
      reset_n = 1'b1;
      ifc_a.run = 1; ifc_b.run = 1; ifc_c.run = 1;
      for (int k = 0; k < 4; k++) begin
         n_total++; if (ifc_a.vc_phase !== 1'(k % 2)) $display("FAIL phase_seq%0d: got %0h want %0h", k, ifc_a.vc_phase, k % 2); else n_pass++;
         if (k < 3) step();
      end
      ifc_a.run = 0;
      ifc_a.in_valid[8] = 1'b1;
      ifc_a.in_data[8*64 +: 64] = mk(4'h0, 4'h0, 48'h99);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h0) $display("FAIL run0_clear: got %0h want 0", ifc_a.in_clear); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         step();
         n_total++; if (ifc_a.vc_phase !== 1'b1) $display("FAIL phase_hold%0d: got %0h want 1", k, ifc_a.vc_phase); else n_pass++;
         n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL run0_enable%0d: got %0h want 0", k, ifc_a.out_enable); else n_pass++;
      end
      ifc_a.in_valid = '0;
      ifc_a.run = 1;
   endtask

   task automatic test_single_hop();
      exp_t e;
      wait_phase_a(0);
      ifc_a.in_valid[8] = 1'b1;
      ifc_a.in_data[8*64 +: 64] = mk(4'h2, 4'h0, 48'h111);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h100) $display("FAIL hop_clear: got %0h want 100", ifc_a.in_clear); else n_pass++;
      exp_q.push_back('{6, mk(4'h1, 4'h0, 48'h111)});
      step();
      ifc_a.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL hop_sb: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_a.out_enable !== (10'h1 << e.idx)) $display("FAIL hop_enable: got %0h want %0h", ifc_a.out_enable, 10'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_a.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL hop_data: got %0h want %0h", ifc_a.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
      end
      step();
      n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL hop_one_cycle: got %0h want 0", ifc_a.out_enable); else n_pass++;
   endtask

   task automatic test_fairness();
      exp_t e;
      int   winners [4] = '{0, 1, 2, 0};
      for (int p = 0; p < 3; p++) ifc_a.in_data[(p*2+1)*64 +: 64] = mk(4'h0, 4'h0, 48'h300 + 48'(p));
      ifc_a.in_valid = 10'b00_0010_1010;
      for (int r = 0; r < 4; r++) begin
         wait_phase_a(1);
         #1;
         n_total++; if (ifc_a.in_clear !== (10'h1 << (winners[r]*2+1))) $display("FAIL rr_clear%0d: got %0h want %0h", r, ifc_a.in_clear, 10'h1 << (winners[r]*2+1)); else n_pass++;
         exp_q.push_back('{9, mk(4'h0, 4'h0, 48'h300 + 48'(winners[r]))});
         step();
         if (exp_q.size() == 0) begin n_total++; $display("FAIL rr_sb%0d: got empty queue want entry", r); end
         else begin
            e = exp_q.pop_front();
            n_total++; if (ifc_a.out_enable !== (10'h1 << e.idx)) $display("FAIL rr_enable%0d: got %0h want %0h", r, ifc_a.out_enable, 10'h1 << e.idx); else n_pass++;
            n_total++; if (ifc_a.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL rr_data%0d: got %0h want %0h", r, ifc_a.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
         end
      end
      ifc_a.in_valid = '0;
   endtask

   task automatic test_backpressure();
      exp_t e;
      ifc_a.out_empty[6] = 1'b0;
      wait_phase_a(0);
      ifc_a.in_valid[2] = 1'b1;
      ifc_a.in_data[2*64 +: 64] = mk(4'h1, 4'h0, 48'h444);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h0) $display("FAIL bp_clear: got %0h want 0", ifc_a.in_clear); else n_pass++;
      step();
      n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL bp_enable: got %0h want 0", ifc_a.out_enable); else n_pass++;
      ifc_a.out_empty[6] = 1'b1;
      wait_phase_a(0);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h004) $display("FAIL bp_release_clear: got %0h want 4", ifc_a.in_clear); else n_pass++;
      exp_q.push_back('{6, mk(4'h0, 4'h0, 48'h444)});
      step();
      ifc_a.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL bp_sb: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_a.out_enable !== (10'h1 << e.idx)) $display("FAIL bp_out_enable: got %0h want %0h", ifc_a.out_enable, 10'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_a.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL bp_data: got %0h want %0h", ifc_a.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
      end
   endtask

   task automatic test_hop_edge_mode();
      exp_t e;
      wait_phase_a(0);
      ifc_a.in_valid[0] = 1'b1;
      ifc_a.in_data[0 +: 64] = mk(4'h8, 4'h3, 48'h555);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h001) $display("FAIL edge_clear: got %0h want 1", ifc_a.in_clear); else n_pass++;
      exp_q.push_back('{4, mk(4'h9, 4'h3, 48'h555)});
      step();
      ifc_a.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL edge_sb: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_a.out_enable !== (10'h1 << e.idx)) $display("FAIL edge_enable: got %0h want %0h", ifc_a.out_enable, 10'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_a.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL edge_data: got %0h want %0h", ifc_a.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
      end
      for (int k = 0; k < 4 && ifc_b.vc_phase != 1'b0; k++) step();
      if (ifc_b.vc_phase != 1'b0) begin n_total++; $display("FAIL phase_wait_b: got %0d want 0", ifc_b.vc_phase); end
      ifc_b.in_valid[8] = 1'b1;
      ifc_b.in_data[8*64 +: 64] = mk(4'h1, 4'hF, 48'h666);
      #1;
      n_total++; if (ifc_b.in_clear !== 10'h100) $display("FAIL yx_clear: got %0h want 100", ifc_b.in_clear); else n_pass++;
      exp_q.push_back('{0, mk(4'h1, 4'h0, 48'h666)});
      step();
      ifc_b.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL yx_sb: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_b.out_enable !== (10'h1 << e.idx)) $display("FAIL yx_enable: got %0h want %0h", ifc_b.out_enable, 10'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_b.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL yx_data: got %0h want %0h", ifc_b.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
      end
   endtask

   task automatic test_uturn();
      exp_t e;
      wait_phase_a(0);
      n_total++; if (ifc_a.uturn_err !== 1'b0) $display("FAIL ut_pre: got %0h want 0", ifc_a.uturn_err); else n_pass++;
      ifc_a.in_valid[4] = 1'b1;
      ifc_a.in_data[4*64 +: 64] = mk(4'hF, 4'h0, 48'h777);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h010) $display("FAIL ut_clear: got %0h want 10", ifc_a.in_clear); else n_pass++;
      step();
      ifc_a.in_valid = '0;
      n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL ut_no_write: got %0h want 0", ifc_a.out_enable); else n_pass++;
      n_total++; if (ifc_a.uturn_err !== 1'b1) $display("FAIL ut_set: got %0h want 1", ifc_a.uturn_err); else n_pass++;
      wait_phase_a(0);
      ifc_a.in_valid[4] = 1'b1;
      ifc_a.err_clear = 1'b1;
      step();
      ifc_a.in_valid = '0;
      n_total++; if (ifc_a.uturn_err !== 1'b1) $display("FAIL ut_set_wins: got %0h want 1", ifc_a.uturn_err); else n_pass++;
      step();
      ifc_a.err_clear = 1'b0;
      n_total++; if (ifc_a.uturn_err !== 1'b0) $display("FAIL ut_cleared: got %0h want 0", ifc_a.uturn_err); else n_pass++;
      wait_phase_a(0);
      ifc_a.in_valid[8] = 1'b1;
      ifc_a.in_data[8*64 +: 64] = mk(4'h0, 4'h0, 48'h7E7);
      #1;
      n_total++; if (ifc_a.in_clear !== 10'h100) $display("FAIL pe_loop_clear: got %0h want 100", ifc_a.in_clear); else n_pass++;
      exp_q.push_back('{8, mk(4'h0, 4'h0, 48'h7E7)});
      step();
      ifc_a.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL pe_loop_sb: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_a.out_enable !== (10'h1 << e.idx)) $display("FAIL pe_loop_enable: got %0h want %0h", ifc_a.out_enable, 10'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_a.out_data[(e.idx/2)*64 +: 64] !== e.dat) $display("FAIL pe_loop_data: got %0h want %0h", ifc_a.out_data[(e.idx/2)*64 +: 64], e.dat); else n_pass++;
      end
      n_total++; if (ifc_a.uturn_err !== 1'b0) $display("FAIL pe_loop_no_err: got %0h want 0", ifc_a.uturn_err); else n_pass++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      ifc_c.in_data[0 +: 64]  = mk(4'h1, 4'h0, 48'hA0);
      ifc_c.in_data[64 +: 64] = mk(4'h1, 4'h0, 48'hA1);
      ifc_c.in_valid = 5'b00011;
      #1;
      n_total++; if (ifc_c.in_clear !== 5'b00001) $display("FAIL b2b_first_clear: got %0h want 1", ifc_c.in_clear); else n_pass++;
      exp_q.push_back('{3, mk(4'h0, 4'h0, 48'hA0)});
      step();
      ifc_c.in_valid = 5'b00010;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL b2b_sb0: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_c.out_enable !== (5'h1 << e.idx)) $display("FAIL b2b_enable0: got %0h want %0h", ifc_c.out_enable, 5'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_c.out_data[e.idx*64 +: 64] !== e.dat) $display("FAIL b2b_data0: got %0h want %0h", ifc_c.out_data[e.idx*64 +: 64], e.dat); else n_pass++;
      end
      #1;
      n_total++; if (ifc_c.in_clear !== 5'b00000) $display("FAIL b2b_inflight: got %0h want 0", ifc_c.in_clear); else n_pass++;
      step();
      n_total++; if (ifc_c.out_enable !== 5'h0) $display("FAIL b2b_bubble: got %0h want 0", ifc_c.out_enable); else n_pass++;
      #1;
      n_total++; if (ifc_c.in_clear !== 5'b00010) $display("FAIL b2b_second_clear: got %0h want 2", ifc_c.in_clear); else n_pass++;
      exp_q.push_back('{3, mk(4'h0, 4'h0, 48'hA1)});
      step();
      ifc_c.in_valid = '0;
      if (exp_q.size() == 0) begin n_total++; $display("FAIL b2b_sb1: got empty queue want entry"); end
      else begin
         e = exp_q.pop_front();
         n_total++; if (ifc_c.out_enable !== (5'h1 << e.idx)) $display("FAIL b2b_enable1: got %0h want %0h", ifc_c.out_enable, 5'h1 << e.idx); else n_pass++;
         n_total++; if (ifc_c.out_data[e.idx*64 +: 64] !== e.dat) $display("FAIL b2b_data1: got %0h want %0h", ifc_c.out_data[e.idx*64 +: 64], e.dat); else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      wait_phase_a(0);
      ifc_a.in_valid[8] = 1'b1;
      ifc_a.in_data[8*64 +: 64] = mk(4'h0, 4'h0, 48'h888);
      step();
      ifc_a.in_valid = '0;
      n_total++; if (ifc_a.out_enable !== 10'h100) $display("FAIL midrst_pre: got %0h want 100", ifc_a.out_enable); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++; if (ifc_a.out_enable !== 10'h0) $display("FAIL midrst_enable: got %0h want 0", ifc_a.out_enable); else n_pass++;
      n_total++; if (ifc_a.out_data !== 320'h0) $display("FAIL midrst_data: got %0h want 0", ifc_a.out_data); else n_pass++;
      n_total++; if (ifc_a.vc_phase !== 1'b0) $display("FAIL midrst_phase: got %0h want 0", ifc_a.vc_phase); else n_pass++;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_hop();
      test_fairness();
      test_backpressure();
      test_hop_edge_mode();
      test_uturn();
      test_back_to_back();
      test_reset_midop();
      n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
